// File: rtl/dma_burst_gen_pkg.sv
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and helpers for the DMA burst generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam int DMA_ADDR_MAX_W = 64;
    localparam int DMA_STRB_MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } dma_bg_st_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ZERO_LEN  = 2'd1,
        ERR_ADDR_WRAP = 2'd2
    } dma_bg_err_e;

    // Sized for the widest legal configuration; instances use the low bits.
    typedef struct packed {
        logic [DMA_ADDR_MAX_W-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [DMA_STRB_MAX_W-1:0] first_strb;
        logic [DMA_STRB_MAX_W-1:0] last_strb;
        logic                      valid;
    } s_dma_burst_req_t;

    // Byte lanes [offset, offset+nbytes) within a beat of bpb bytes.
    function automatic logic [DMA_STRB_MAX_W-1:0] calc_strb(
        input int offset,
        input int nbytes,
        input int bpb
    );
        logic [DMA_STRB_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < DMA_STRB_MAX_W; i++) begin
            m[i] = (i >= offset) && (i < offset + nbytes) && (i < bpb);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_burst_split.sv
// ============================================================================
// Module      : dma_burst_split
// Description : Combinational sizing of the next burst: beat count, AxLEN,
//               head/tail strobes and bytes consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_burst_split
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 256,
    parameter int BOUND     = 4096
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LEN_W-1:0]      bytes,
    input  logic                  first,
    output logic [ADDR_W-1:0]     aligned_addr,
    output logic [8:0]            beats,
    output logic [7:0]            len,
    output logic [DATA_W/8-1:0]   first_strb,
    output logic [DATA_W/8-1:0]   last_strb,
    output logic                  is_last,
    output logic [LEN_W-1:0]      consumed
);

    localparam int BPB       = DATA_W / 8;
    localparam int LOG_BPB   = $clog2(BPB);
    localparam int LOG_BOUND = $clog2(BOUND);
    localparam int CW        = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

    localparam logic [CW-1:0] C_BPB_M1      = CW'(BPB - 1);
    localparam logic [CW-1:0] C_MAX_BEATS   = CW'(MAX_BEATS);
    localparam logic [CW-1:0] C_BOUND_BEATS = CW'(BOUND / BPB);

    logic [CW-1:0]             w_off;
    logic [CW-1:0]             w_tot;
    logic [CW-1:0]             w_rem_beats;
    logic [CW-1:0]             w_bnd_off;
    logic [CW-1:0]             w_bnd_beats;
    logic [CW-1:0]             w_beats;
    logic [CW-1:0]             w_end_off;
    logic [DMA_STRB_MAX_W-1:0] w_head_full;
    logic [DMA_STRB_MAX_W-1:0] w_tail_full;
    logic [BPB-1:0]            w_head;
    logic [BPB-1:0]            w_tail;

    assign w_off       = CW'(addr[LOG_BPB-1:0]);
    assign w_tot       = CW'(bytes) + w_off;
    assign w_rem_beats = (w_tot + C_BPB_M1) >> LOG_BPB;
    assign w_bnd_off   = CW'(addr[LOG_BOUND-1:0]) >> LOG_BPB;
    assign w_bnd_beats = C_BOUND_BEATS - w_bnd_off;
    assign w_end_off   = (w_tot - CW'(1)) & C_BPB_M1;

    always_comb begin
        w_beats = w_rem_beats;
        if (C_MAX_BEATS < w_beats) w_beats = C_MAX_BEATS;
        if (w_bnd_beats < w_beats) w_beats = w_bnd_beats;
    end

    assign aligned_addr = {addr[ADDR_W-1:LOG_BPB], {LOG_BPB{1'b0}}};
    assign beats        = 9'(w_beats);
    assign len          = 8'(w_beats - CW'(1));
    assign is_last      = (w_rem_beats == w_beats);
    assign consumed     = LEN_W'((w_beats << LOG_BPB) - w_off);

    assign w_head_full = calc_strb(int'(w_off), BPB, BPB);
    assign w_tail_full = calc_strb(0, int'(w_end_off) + 1, BPB);
    assign w_head      = first   ? w_head_full[BPB-1:0] : '1;
    assign w_tail      = is_last ? w_tail_full[BPB-1:0] : '1;

    // A single-beat burst carries both the head and tail restriction.
    assign first_strb = (w_beats == CW'(1)) ? (w_head & w_tail) : w_head;
    assign last_strb  = (w_beats == CW'(1)) ? (w_head & w_tail) : w_tail;

endmodule

`default_nettype wire

// File: rtl/dma_burst_gen.sv
// ============================================================================
// Module      : dma_burst_gen
// Description : Splits one DMA descriptor into AXI INCR burst requests with
//               head/tail strobes and an outstanding-burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_burst_gen
    import dma_pkg::*;
#(
    parameter bit STREAM_TYPE = 1'b0,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 512,
    parameter int MAX_BEATS   = 256,
    parameter int BOUND       = 4096,
    parameter int MAX_OUTST   = 4,
    parameter int LEN_W       = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  go_i,
    input  logic [ADDR_W-1:0]     src_addr_i,
    input  logic [ADDR_W-1:0]     dst_addr_i,
    input  logic [LEN_W-1:0]      num_bytes_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_W-1:0]     req_addr_o,
    output logic [7:0]            req_len_o,
    output logic [2:0]            req_size_o,
    output logic [DATA_W/8-1:0]   req_first_strb_o,
    output logic [DATA_W/8-1:0]   req_last_strb_o,
    input  logic                  txn_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam int BPB     = DATA_W / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int CW      = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;
    localparam int OW      = $clog2(MAX_OUTST + 1);

    localparam logic [OW-1:0] C_MAX_OUTST = OW'(MAX_OUTST);

    dma_bg_st_t        r_state;
    dma_bg_err_e       r_err_code;
    s_dma_burst_req_t  r_req;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_rem_bytes;
    logic              r_first;
    logic              r_is_last;
    logic [LEN_W-1:0]  r_consumed;
    logic [8:0]        r_beats;
    logic [OW-1:0]     r_outst;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_base;
    logic [CW-1:0]     w_end;
    logic              w_wrap;
    logic              w_hs;
    logic              w_dec;
    logic [ADDR_W-1:0] w_aligned;
    logic [8:0]        w_beats;
    logic [7:0]        w_len;
    logic [BPB-1:0]    w_first_strb;
    logic [BPB-1:0]    w_last_strb;
    logic              w_is_last;
    logic [LEN_W-1:0]  w_consumed;
    logic [$bits(s_dma_burst_req_t)-1:0] w_req_unused;

    dma_burst_split #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .BOUND     (BOUND)
    ) u_split (
        .addr         (r_cur_addr),
        .bytes        (r_rem_bytes),
        .first        (r_first),
        .aligned_addr (w_aligned),
        .beats        (w_beats),
        .len          (w_len),
        .first_strb   (w_first_strb),
        .last_strb    (w_last_strb),
        .is_last      (w_is_last),
        .consumed     (w_consumed)
    );

    assign w_base = STREAM_TYPE ? dst_addr_i : src_addr_i;
    assign w_end  = CW'(w_base) + CW'(num_bytes_i) - CW'(1);
    assign w_wrap = |(w_end >> ADDR_W);

    assign req_valid_o      = r_req.valid && (r_outst < C_MAX_OUTST);
    assign req_addr_o       = r_req.addr[ADDR_W-1:0];
    assign req_len_o        = r_req.len;
    assign req_size_o       = r_req.size;
    assign req_first_strb_o = r_req.first_strb[BPB-1:0];
    assign req_last_strb_o  = r_req.last_strb[BPB-1:0];
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign err_code_o       = r_err_code;
    assign w_req_unused     = r_req;

    assign w_hs  = req_valid_o && req_ready_i;
    assign w_dec = txn_done_i && (r_outst != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_err_code  <= ERR_NONE;
            r_req       <= '0;
            r_cur_addr  <= '0;
            r_rem_bytes <= '0;
            r_first     <= 1'b0;
            r_is_last   <= 1'b0;
            r_consumed  <= '0;
            r_beats     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go_i) begin
                        if (num_bytes_i == '0) begin
                            r_err      <= 1'b1;
                            r_done     <= 1'b1;
                            r_err_code <= ERR_ZERO_LEN;
                        end else if (w_wrap) begin
                            r_err      <= 1'b1;
                            r_done     <= 1'b1;
                            r_err_code <= ERR_ADDR_WRAP;
                        end else begin
                            r_err_code  <= ERR_NONE;
                            r_cur_addr  <= w_base;
                            r_rem_bytes <= num_bytes_i;
                            r_first     <= 1'b1;
                            r_state     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_req.addr       <= DMA_ADDR_MAX_W'(w_aligned);
                    r_req.len        <= w_len;
                    r_req.size       <= 3'(LOG_BPB);
                    r_req.first_strb <= DMA_STRB_MAX_W'(w_first_strb);
                    r_req.last_strb  <= DMA_STRB_MAX_W'(w_last_strb);
                    r_req.valid      <= 1'b1;
                    r_is_last        <= w_is_last;
                    r_consumed       <= w_consumed;
                    r_beats          <= w_beats;
                    r_state          <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_hs) begin
                        r_req.valid <= 1'b0;
                        // Only the final burst may advance to the top of the
                        // address space; that value is never used afterwards.
                        r_cur_addr  <= r_req.addr[ADDR_W-1:0]
                                       + ADDR_W'({r_beats, {LOG_BPB{1'b0}}});
                        r_rem_bytes <= r_rem_bytes - r_consumed;
                        r_first     <= 1'b0;
                        r_state     <= r_is_last ? ST_DRAIN : ST_CALC;
                    end
                end
                ST_DRAIN: begin
                    if (r_outst == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outst <= '0;
        end else begin
            case ({w_hs, w_dec})
                2'b10:   r_outst <= r_outst + OW'(1);
                2'b01:   r_outst <= r_outst - OW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_burst_gen.sv
// ============================================================================
// Module      : tb_dma_burst_gen
// Description : Directed and random descriptors checked against a byte-range
//               model of the burst stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_burst_gen;

    localparam int  C_BPB   = 64;
    localparam int  C_BOUND = 4096;
    localparam int  C_MAXB  = 256;
    localparam int  C_OUTST = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        go_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [31:0] num_bytes_i = '0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [31:0] req_addr_o;
    logic [7:0]  req_len_o;
    logic [2:0]  req_size_o;
    logic [63:0] req_first_strb_o;
    logic [63:0] req_last_strb_o;
    logic        txn_done_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int errors = 0;
    int checks = 0;

    longint      exp_addr[$];
    longint      exp_len[$];
    logic [63:0] exp_fs[$];
    logic [63:0] exp_ls[$];

    dma_burst_gen #(
        .STREAM_TYPE (1'b0),
        .ADDR_W      (32),
        .DATA_W      (512),
        .MAX_BEATS   (C_MAXB),
        .BOUND       (C_BOUND),
        .MAX_OUTST   (C_OUTST),
        .LEN_W       (32)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .go_i             (go_i),
        .src_addr_i       (src_addr_i),
        .dst_addr_i       (dst_addr_i),
        .num_bytes_i      (num_bytes_i),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .req_len_o        (req_len_o),
        .req_size_o       (req_size_o),
        .req_first_strb_o (req_first_strb_o),
        .req_last_strb_o  (req_last_strb_o),
        .txn_done_i       (txn_done_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .err_code_o       (err_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference: every burst covers whole beats of the byte range [a, a+n-1],
    // cut at MAX_BEATS and at each BOUND line; a lane is enabled iff its byte
    // address lies inside the range.
    task automatic build_model(input longint a, input longint n);
        longint cur, lastb, al, rem, bnd, beats, tail;
        logic [63:0] fs, ls;
        exp_addr.delete(); exp_len.delete(); exp_fs.delete(); exp_ls.delete();
        lastb = a + n - 1;
        cur   = a;
        while (cur <= lastb) begin
            al    = cur - (cur % C_BPB);
            rem   = (lastb - al) / C_BPB + 1;
            bnd   = (C_BOUND - (al % C_BOUND)) / C_BPB;
            beats = rem;
            if (beats > C_MAXB) beats = C_MAXB;
            if (bnd < beats)    beats = bnd;
            tail = al + (beats - 1) * C_BPB;
            for (int j = 0; j < C_BPB; j++) begin
                fs[j] = (al + j >= a) && (al + j <= lastb);
                ls[j] = (tail + j >= a) && (tail + j <= lastb);
            end
            exp_addr.push_back(al);
            exp_len.push_back(beats - 1);
            exp_fs.push_back(fs);
            exp_ls.push_back(ls);
            cur = al + beats * C_BPB;
        end
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("valid_timeout", 64'(seen), 64'd1);
        if (!seen) finish_now();
    endtask

    task automatic pulse_done();
        txn_done_i = 1'b1;
        @(negedge clk);
        txn_done_i = 1'b0;
    endtask

    task automatic run_desc(input longint a, input longint n, input bit hold);
        int     outst = 0;
        longint sum   = 0;
        longint beats;
        bit     co, seen;
        build_model(a, n);
        @(negedge clk);
        src_addr_i  = 32'(a);
        dst_addr_i  = $urandom;
        num_bytes_i = 32'(n);
        go_i        = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
        chk("busy_start", 64'(busy_o), 64'd1);
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (outst == C_OUTST) begin
                repeat (3) @(negedge clk);
                chk("throttle", 64'(req_valid_o), 64'd0);
                pulse_done();
                outst--;
            end else if (!hold && outst > 0 && $urandom_range(0, 1) == 1) begin
                pulse_done();
                outst--;
            end
            wait_valid();
            chk("addr", 64'(req_addr_o), 64'(exp_addr[k]));
            chk("len",  64'(req_len_o),  64'(exp_len[k]));
            chk("size", 64'(req_size_o), 64'd6);
            chk("first_strb", req_first_strb_o, exp_fs[k]);
            chk("last_strb",  req_last_strb_o,  exp_ls[k]);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("hold_valid", 64'(req_valid_o), 64'd1);
                chk("hold_addr",  64'(req_addr_o),  64'(exp_addr[k]));
            end
            beats = longint'(req_len_o) + 1;
            if (beats == 1) sum += $countones(req_first_strb_o);
            else sum += $countones(req_first_strb_o) + $countones(req_last_strb_o)
                        + (beats - 2) * C_BPB;
            co = !hold && outst > 0 && $urandom_range(0, 1) == 1;
            req_ready_i = 1'b1;
            txn_done_i  = co;
            @(negedge clk);
            req_ready_i = 1'b0;
            txn_done_i  = 1'b0;
            if (!co) outst++;
        end
        chk("strb_sum", 64'(sum), 64'(n));
        while (outst > 0) begin
            chk("early_done", 64'(done_o), 64'd0);
            pulse_done();
            outst--;
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done", 64'(seen), 64'd1);
        chk("err_after_ok", 64'(err_code_o), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done_o), 64'd0);
        chk("busy_end", 64'(busy_o), 64'd0);
    endtask

    task automatic run_err(input longint a, input longint n, input logic [1:0] code);
        @(negedge clk);
        src_addr_i  = 32'(a);
        num_bytes_i = 32'(n);
        go_i        = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
        chk("err_pulse",  64'(err_o),      64'd1);
        chk("err_done",   64'(done_o),     64'd1);
        chk("err_code",   64'(err_code_o), 64'(code));
        chk("err_busy",   64'(busy_o),     64'd0);
        chk("err_valid",  64'(req_valid_o), 64'd0);
        @(negedge clk);
        chk("err_clear",  64'(err_o),      64'd0);
        chk("err_held",   64'(err_code_o), 64'(code));
        repeat (3) begin
            @(negedge clk);
            chk("err_novalid", 64'(req_valid_o), 64'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(req_valid_o), 64'd0);
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_done",  64'(done_o),      64'd0);
        chk("rst_err",   64'(err_o),       64'd0);
        chk("rst_code",  64'(err_code_o),  64'd0);
        chk("rst_addr",  64'(req_addr_o),  64'd0);
        rstn = 1'b1;

        run_desc(64'h1000, 16384, 1'b0);
        run_desc(64'h0FC0, 128,   1'b0);
        run_desc(64'h1010, 100,   1'b0);
        run_desc(64'h2004, 8,     1'b0);
        run_desc(64'h0,    65536, 1'b1);
        run_err(64'h1234, 0, 2'd1);
        run_err(64'hFFFF_FFF0, 32, 2'd2);
        run_desc(64'hFFFF_FFC0, 64, 1'b0);
        run_desc(64'h0000_0FFF, 2,  1'b0);

        // Asynchronous reset while a request is pending.
        @(negedge clk);
        src_addr_i  = 32'h3000;
        num_bytes_i = 32'd8192;
        go_i        = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
        wait_valid();
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(req_valid_o), 64'd0);
        chk("rst_mid_busy",  64'(busy_o),      64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_done", 64'(done_o), 64'd0);
        end
        rstn = 1'b1;

        for (int r = 0; r < 12; r++) begin
            run_desc(longint'($urandom_range(0, 32'h00FF_FFFF)),
                     longint'($urandom_range(1, 12000)), 1'b0);
        end

        finish_now();
    end

endmodule

`default_nettype wire
